alu_cmd_sequencer: RTL and testbench

Packet-level controller between the UART byte streams and the ALU datapath in `top`. It parses command packets from `uart_rx`: a 4-byte header (opcode, 0x00, length LE) followed by 32-bit little-endian operands. It folds the operands through a multi-cycle ALU using a start/done handshake, then serializes the 4-byte or 8-byte result into `uart_tx`.

---
 rtl/alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// alu_cmd_sequencer : parses UART command packets, folds the operands through
//                     a start/done ALU and streams the result back out.
// Revision          : 1.0
// ============================================================================
module alu_cmd_sequencer #(
    parameter logic [15:0] MaxLen = 16'd1028
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        op_start_o,
    output logic [1:0]  op_code_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    input  logic        op_done_i,
    input  logic [31:0] op_result_i,
    input  logic [31:0] op_rem_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        OPND  = 3'd1,
        EXEC  = 3'd2,
        SEND  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [7:0] OPC_ADD = 8'hAD;
    localparam logic [7:0] OPC_MUL = 8'h63;
    localparam logic [7:0] OPC_DIV = 8'h5B;

    state_e      state_q,    state_d;
    logic [1:0]  hdr_cnt_q,  hdr_cnt_d;
    logic [23:0] hdr_q,      hdr_d;
    logic [1:0]  opnd_cnt_q, opnd_cnt_d;
    logic [23:0] opnd_q,     opnd_d;
    logic        first_q,    first_d;
    logic [13:0] ops_left_q, ops_left_d;
    logic [1:0]  code_q,     code_d;
    logic [31:0] acc_q,      acc_d;
    logic [31:0] rem_q,      rem_d;
    logic [31:0] opb_q,      opb_d;
    logic        start_q,    start_d;
    logic        err_q,      err_d;
    logic [15:0] drain_q,    drain_d;
    logic [2:0]  tx_idx_q,   tx_idx_d;
    logic        tx_vld_q,   tx_vld_d;

    logic        rx_fire;
    logic [15:0] hdr_len;
    logic [31:0] opnd_word;
    logic        hdr_known;
    logic [1:0]  hdr_code;
    logic        hdr_ok;
    logic [2:0]  tx_last;
    logic [63:0] tx_res;

    assign rx_ready_o = !rst_i && ((state_q == HDR) || (state_q == OPND) || (state_q == DRAIN));
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign hdr_len    = {rx_data_i, hdr_q[23:16]};
    assign opnd_word  = {rx_data_i, opnd_q};
    assign tx_last    = (code_q == 2'd2) ? 3'd7 : 3'd3;
    assign tx_res     = {rem_q, acc_q};

    assign tx_data_o  = tx_res[{tx_idx_q, 3'b000} +: 8];
    assign tx_valid_o = tx_vld_q;
    assign op_start_o = start_q;
    assign op_code_o  = code_q;
    assign op_a_o     = acc_q;
    assign op_b_o     = opb_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != HDR) || (hdr_cnt_q != 2'd0);

    always_comb begin
        hdr_known = 1'b1;
        hdr_code  = 2'd0;
        case (hdr_q[7:0])
            OPC_ADD: hdr_code = 2'd0;
            OPC_MUL: hdr_code = 2'd1;
            OPC_DIV: hdr_code = 2'd2;
            default: hdr_known = 1'b0;
        endcase
    end

    assign hdr_ok = hdr_known && (hdr_q[15:8] == 8'h00) && (hdr_len[1:0] == 2'b00)
                 && (hdr_len >= 16'd12) && (hdr_len <= MaxLen)
                 && ((hdr_code != 2'd2) || (hdr_len == 16'd12));

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        hdr_d      = hdr_q;
        opnd_cnt_d = opnd_cnt_q;
        opnd_d     = opnd_q;
        first_d    = first_q;
        ops_left_d = ops_left_q;
        code_d     = code_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        opb_d      = opb_q;
        start_d    = 1'b0;
        err_d      = 1'b0;
        drain_d    = drain_q;
        tx_idx_d   = tx_idx_q;
        tx_vld_d   = tx_vld_q;

        case (state_q)
            HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    hdr_d     = {rx_data_i, hdr_q[23:8]};
                    if (hdr_cnt_q == 2'd3) begin
                        if (hdr_ok) begin
                            code_d     = hdr_code;
                            ops_left_d = hdr_len[15:2] - 14'd1;
                            first_d    = 1'b1;
                            opnd_cnt_d = 2'd0;
                            state_d    = OPND;
                        end else begin
                            // Rejected packets still have their body swallowed so the
                            // stream stays aligned to the next header.
                            err_d   = 1'b1;
                            drain_d = (hdr_len >= 16'd4) ? (hdr_len - 16'd4) : 16'd0;
                            state_d = (hdr_len > 16'd4) ? DRAIN : HDR;
                        end
                    end
                end
            end
            OPND: begin
                if (rx_fire) begin
                    opnd_cnt_d = opnd_cnt_q + 2'd1;
                    opnd_d     = {rx_data_i, opnd_q[23:8]};
                    if (opnd_cnt_q == 2'd3) begin
                        ops_left_d = ops_left_q - 14'd1;
                        if (first_q) begin
                            acc_d   = opnd_word;
                            first_d = 1'b0;
                        end else begin
                            opb_d   = opnd_word;
                            start_d = 1'b1;
                            state_d = EXEC;
                        end
                    end
                end
            end
            EXEC: begin
                if (op_done_i) begin
                    acc_d    = op_result_i;
                    rem_d    = op_rem_i;
                    tx_idx_d = 3'd0;
                    tx_vld_d = 1'b0;
                    state_d  = (ops_left_q != 14'd0) ? OPND : SEND;
                end
            end
            SEND: begin
                if (!tx_vld_q) begin
                    tx_vld_d = 1'b1;
                end else if (tx_ready_i) begin
                    if (tx_idx_q == tx_last) begin
                        tx_vld_d = 1'b0;
                        state_d  = HDR;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (rx_fire) begin
                    drain_d = drain_q - 16'd1;
                    if (drain_q == 16'd1) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= HDR;
            hdr_cnt_q  <= 2'd0;
            hdr_q      <= 24'd0;
            opnd_cnt_q <= 2'd0;
            opnd_q     <= 24'd0;
            first_q    <= 1'b0;
            ops_left_q <= 14'd0;
            code_q     <= 2'd0;
            acc_q      <= 32'd0;
            rem_q      <= 32'd0;
            opb_q      <= 32'd0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            drain_q    <= 16'd0;
            tx_idx_q   <= 3'd0;
            tx_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            hdr_q      <= hdr_d;
            opnd_cnt_q <= opnd_cnt_d;
            opnd_q     <= opnd_d;
            first_q    <= first_d;
            ops_left_q <= ops_left_d;
            code_q     <= code_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            opb_q      <= opb_d;
            start_q    <= start_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
            tx_idx_q   <= tx_idx_d;
            tx_vld_q   <= tx_vld_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_sequencer : scoreboard bench with a behavioural ALU and a packet
//                        level reference model.
// Revision             : 1.0
// ============================================================================
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        op_start_o;
    logic [1:0]  op_code_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        op_done_i;
    logic [31:0] op_result_i;
    logic [31:0] op_rem_i;
    logic        busy_o;
    logic        err_o;

    alu_cmd_sequencer #(.MaxLen(16'd1028)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .op_start_o  (op_start_o),
        .op_code_o   (op_code_o),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .op_done_i   (op_done_i),
        .op_result_i (op_result_i),
        .op_rem_i    (op_rem_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    int          err_seen = 0;
    int          n_starts = 0;
    int          tx_hs_cnt = 0;
    int          alu_fix_lat = 0;
    bit          bp_hold = 1'b0;
    bit          alu_busy = 1'b0;
    logic [1:0]  last_code = 2'd0;
    logic [7:0]  exp_q[$];
    logic [31:0] ops[0:511];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Behavioural ALU: returns {remainder, result}; divide-by-zero gives all ones / dividend.
    function automatic logic [63:0] alu_fn(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (c)
            2'd0:    return {32'd0, a + b};
            2'd1:    begin p = {32'd0, a} * {32'd0, b}; return {32'd0, p[31:0]}; end
            default: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                     else            return {a % b, a / b};
        endcase
    endfunction

    function automatic logic [7:0] opc_of(input logic [1:0] c);
        case (c)
            2'd0:    return 8'hAD;
            2'd1:    return 8'h63;
            default: return 8'h5B;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Reference model: fold operands left to right, response is result LE (+ remainder LE for div).
    task automatic push_model(input logic [1:0] c, input int n);
        logic [31:0] acc;
        logic [31:0] rem;
        logic [63:0] r;
        acc = ops[0];
        rem = 32'd0;
        for (int i = 1; i < n; i++) begin
            r   = alu_fn(c, acc, ops[i]);
            acc = r[31:0];
            rem = r[63:32];
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(acc[8*i +: 8]);
        if (c == 2'd2) for (int i = 0; i < 4; i++) exp_q.push_back(rem[8*i +: 8]);
    endtask

    // Called and returns at posedge+1; the byte is taken on the edge after a negedge with ready high.
    task automatic send_byte(input logic [7:0] b);
        int  t;
        bit  done;
        if ($urandom_range(0, 3) == 0) begin
            rx_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        t    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rx_ready_o) begin
                done = 1'b1;
                @(posedge clk); #1;
            end else begin
                t++;
                if (t > 3000) begin
                    checks++; errors++;
                    $display("FAIL rx_accept_timeout: got no ready, required ready within 3000 cycles");
                    done = 1'b1;
                    @(posedge clk); #1;
                end
            end
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] opc, input logic [7:0] b1, input logic [15:0] len,
                               input int nbody, input bit bad);
        send_byte(opc);
        send_byte(b1);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        chk("err_after_header", err_o, bad);
        if (bad) begin
            err_exp++;
            @(posedge clk); #1;
            chk("err_one_cycle", err_o, 1'b0);
        end
        for (int i = 0; i < nbody; i++) send_byte(ops[i/4][8*(i%4) +: 8]);
    endtask

    task automatic send_valid(input logic [1:0] c, input int n);
        push_model(c, n);
        send_packet(opc_of(c), 8'h00, 16'(4 + 4*n), 4*n, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !busy_o && !alu_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", (t >= 20000), 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic chk_rst(input string nm);
        chk(nm, {rx_ready_o, tx_valid_o, tx_data_o, op_start_o, op_code_o, busy_o, err_o}, 64'd0);
        chk(nm, {op_a_o, op_b_o}, 64'd0);
    endtask

    // tx_ready driver
    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ALU model: one operation at a time, latency fixed or random.
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
        logic [63:0] r;
        int          lat;
        bit          aborted;
        op_done_i   = 1'b0;
        op_result_i = 32'd0;
        op_rem_i    = 32'd0;
        forever begin
            @(negedge clk);
            if (op_start_o && !rst_i) begin
                a = op_a_o; b = op_b_o; c = op_code_o;
                n_starts++;
                last_code = c;
                alu_busy  = 1'b1;
                aborted   = 1'b0;
                lat = (alu_fix_lat != 0) ? alu_fix_lat : $urandom_range(1, 4);
                repeat (lat) begin
                    @(negedge clk);
                    if (rst_i) aborted = 1'b1;
                    if (!aborted) begin
                        chk("alu_operands_stable", {c, a, b}, {op_code_o, op_a_o, op_b_o});
                        chk("rx_ready_in_exec", rx_ready_o, 1'b0);
                    end
                end
                r = alu_fn(c, a, b);
                op_done_i   = 1'b1;
                op_result_i = r[31:0];
                op_rem_i    = r[63:32];
                @(negedge clk);
                op_done_i   = 1'b0;
                alu_busy    = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard
    initial begin
        logic [7:0] e;
        logic [7:0] prev_data;
        bit         prev_stall;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (err_o) err_seen++;
                if (prev_stall) chk("tx_hold_stable", {tx_valid_o, tx_data_o}, {1'b1, prev_data});
                if (tx_valid_o) chk("rx_ready_in_send", rx_ready_o, 1'b0);
                if (tx_valid_o && tx_ready_i) begin
                    tx_hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected: got byte %0h, required no byte", tx_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_data_o, e);
                    end
                end
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_data  = tx_data_o;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 3 ms");
        $fatal(1);
    end

    initial begin
        int          s0;
        int          cnt;
        int          kind;
        int          n;
        logic [1:0]  c;
        logic [7:0]  held;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'd0;
        repeat (3) @(negedge clk);
        chk_rst("reset_outputs");
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Add with wrap: FFFFFFFF + 2 + 3 = 4
        ops[0] = 32'hFFFF_FFFF; ops[1] = 32'd2; ops[2] = 32'd3;
        exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        s0 = n_starts;
        send_packet(8'hAD, 8'h00, 16'h0010, 12, 1'b0);
        wait_idle();
        chk("add_start_count", n_starts - s0, 2);

        // Mul: 0x00010001^2 = 0x00020001
        ops[0] = 32'h0001_0001; ops[1] = 32'h0001_0001;
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h02); exp_q.push_back(8'h00);
        send_packet(8'h63, 8'h00, 16'h000C, 8, 1'b0);
        wait_idle();
        chk("mul_op_code", last_code, 2'd1);

        // Div 100/7 with fixed ALU latency 3: first tx_valid 5 edges after last rx byte
        alu_fix_lat = 3;
        ops[0] = 32'd100; ops[1] = 32'd7;
        exp_q.push_back(8'h0E); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_packet(8'h5B, 8'h00, 16'h000C, 8, 1'b0);
        cnt = 0;
        while (!tx_valid_o && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("div_tx_latency", cnt, 5);
        wait_idle();
        alu_fix_lat = 0;

        // Bad headers, each followed by a valid packet
        for (int i = 0; i < 16; i++) ops[i] = rand_word();
        send_packet(8'h42, 8'h00, 16'h000C, 8, 1'b1);
        ops[0] = 32'd5; ops[1] = 32'd6; send_valid(2'd0, 2);
        wait_idle();
        for (int i = 0; i < 16; i++) ops[i] = rand_word();
        send_packet(8'h5B, 8'h00, 16'h0010, 12, 1'b1);
        ops[0] = 32'd9; ops[1] = 32'd4; send_valid(2'd2, 2);
        wait_idle();
        for (int i = 0; i < 16; i++) ops[i] = rand_word();
        send_packet(8'hAD, 8'h00, 16'h000A, 6, 1'b1);
        ops[0] = 32'd7; ops[1] = 32'd8; ops[2] = 32'd9; send_valid(2'd1, 3);
        wait_idle();
        send_packet(8'hAD, 8'h01, 16'h000C, 8, 1'b1);
        send_packet(8'h63, 8'h00, 16'h0002, 0, 1'b1);
        for (int i = 0; i < 260; i++) ops[i] = rand_word();
        send_packet(8'hAD, 8'h00, 16'd1032, 1028, 1'b1);
        send_valid(2'd0, 256);
        wait_idle();

        // Backpressure mid-SEND
        ops[0] = 32'd1000; ops[1] = 32'd3;
        s0 = tx_hs_cnt;
        send_valid(2'd2, 2);
        cnt = 0;
        while (tx_hs_cnt < s0 + 2 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_reach_send", (cnt >= 500), 1'b0);
        @(posedge clk);
        bp_hold = 1'b1;
        @(negedge clk);
        held = tx_data_o;
        repeat (50) @(negedge clk);
        chk("bp_held_byte", {tx_valid_o, tx_data_o}, {1'b1, held});
        @(posedge clk);
        bp_hold = 1'b0;
        wait_idle();

        // Reset while the first ALU operation of an add is outstanding
        alu_fix_lat = 8;
        ops[0] = 32'd11; ops[1] = 32'd22;
        send_byte(8'hAD); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 8; i++) send_byte(ops[i/4][8*(i%4) +: 8]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk_rst("reset_mid_op");
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        alu_fix_lat = 0;
        ops[0] = 32'd1; ops[1] = 32'd2;
        exp_q.push_back(8'h03); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_packet(8'hAD, 8'h00, 16'h000C, 8, 1'b0);
        wait_idle();

        // Randomized packets against the reference model
        for (int p = 0; p < 1000; p++) begin
            for (int i = 0; i < 8; i++) ops[i] = rand_word();
            kind = $urandom_range(0, 19);
            if (kind < 17) begin
                c = 2'($urandom_range(0, 2));
                n = (c == 2'd2) ? 2 : $urandom_range(2, 5);
                if (c == 2'd2 && $urandom_range(0, 3) != 0 && ops[1] == 32'd0) ops[1] = 32'd1;
                send_valid(c, n);
            end else begin
                case ($urandom_range(0, 4))
                    0: send_packet(8'h42, 8'h00, 16'd12, 8, 1'b1);
                    1: send_packet(8'h5B, 8'h00, 16'd20, 16, 1'b1);
                    2: send_packet(8'hAD, 8'h00, 16'd14, 10, 1'b1);
                    3: send_packet(8'h63, 8'h01, 16'd12, 8, 1'b1);
                    default: send_packet(8'hAD, 8'h00, 16'd8, 4, 1'b1);
                endcase
            end
        end
        wait_idle();
        chk("err_pulse_count", err_seen, err_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
